// File: rtl/goldschmidt_div.sv
`default_nettype none
// ============================================================================
// Module      : goldschmidt_div
// Description : Handshaked unsigned integer divider based on Goldschmidt
//               iteration. The operands are normalised, N/D/F are refined for
//               ITERS cycles, the quotient estimate is truncated, and a single
//               correction step produces the exact floor quotient and its
//               remainder. A zero divisor bypasses the datapath and sets dbz.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset (overrides i_en)
//   i_en         in   1      global stall; 0 freezes all state and handshakes
//   i_in_valid   in   1      operand pair valid
//   o_in_ready   out  1      block can accept operands (IDLE only)
//   i_a          in   WIDTH  dividend
//   i_b          in   WIDTH  divisor
//   o_out_valid  out  1      result valid
//   i_out_ready  in   1      consumer accepts result
//   o_q          out  WIDTH  floor(a/b), all ones on divide-by-zero
//   o_r          out  WIDTH  a - q*b, a on divide-by-zero
//   o_dbz        out  1      divide-by-zero flag, qualified by o_out_valid
//   o_est_valid  out  1      one pulse per Goldschmidt iteration
//   o_est_idx    out  IDX_W  iteration index of o_est_q
//   o_est_q      out  WIDTH  truncated quotient estimate after that iteration
// ============================================================================
module goldschmidt_div #(
  parameter int WIDTH  = 32,
  parameter int ITERS  = 5,
  parameter int FRAC_W = WIDTH + 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_en,
  input  logic                                          i_in_valid,
  output logic                                          o_in_ready,
  input  logic [WIDTH-1:0]                              i_a,
  input  logic [WIDTH-1:0]                              i_b,
  output logic                                          o_out_valid,
  input  logic                                          i_out_ready,
  output logic [WIDTH-1:0]                              o_q,
  output logic [WIDTH-1:0]                              o_r,
  output logic                                          o_dbz,
  output logic                                          o_est_valid,
  output logic [((ITERS > 1) ? $clog2(ITERS) : 1)-1:0] o_est_idx,
  output logic [WIDTH-1:0]                              o_est_q
);

  localparam int IDX_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int LZ_W  = $clog2(WIDTH + 1);
  // D and F: 2 integer bits + FRAC_W fraction bits.
  localparam int DW    = FRAC_W + 2;
  // N carries the unnormalised quotient: WIDTH+1 integer bits so the
  // estimate can be saturated rather than wrapped.
  localparam int NW    = WIDTH + 1 + FRAC_W;
  localparam int RW    = WIDTH + 2;

  localparam logic [DW-1:0]    c_TWO  = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_NORM    = 3'd1,
    S_ITER    = 3'd2,
    S_DENORM  = 3'd3,
    S_CORRECT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_dbz;
  logic               r_est_valid;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_est_q;
  logic [IDX_W-1:0]   r_est_idx;
  logic [IDX_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [NW-1:0]      r_n;
  logic [DW-1:0]      r_d;
  logic [DW-1:0]      r_f;
  logic [WIDTH-1:0]   r_qtmp;

  logic [LZ_W-1:0]         w_lzc;
  logic                    w_found;
  logic [WIDTH-1:0]        w_bn;
  logic [DW-1:0]           w_d0;
  logic [NW-1:0]           w_n0;
  logic [2*DW-1:0]         w_dprod;
  logic [NW+DW-1:0]        w_nprod;
  logic [DW-1:0]           w_d_new;
  logic [NW-1:0]           w_n_new;
  logic [WIDTH-1:0]        w_est_sat;
  logic [WIDTH-1:0]        w_qtmp_sat;
  logic [2*WIDTH-1:0]      w_qb;
  logic signed [RW-1:0]    w_b_ext;
  logic signed [RW-1:0]    w_rem;
  logic signed [RW-1:0]    w_rem_add;
  logic signed [RW-1:0]    w_rem_sub;
  logic                    w_unused_bits;

  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH:0] v);
    f_sat = v[WIDTH] ? {WIDTH{1'b1}} : v[WIDTH-1:0];
  endfunction

  // Leading-zero count of the latched divisor (only used while it is nonzero).
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_b[i]) begin
          w_found = 1'b1;
        end else begin
          w_lzc = w_lzc + LZ_W'(1);
        end
      end
    end
  end

  // Normalisation: b<<s read as a 0.WIDTH fraction lands in [0.5,1); a is
  // shifted by the same amount so N/D still equals a/b.
  assign w_bn = r_b << w_lzc;
  assign w_d0 = DW'(w_bn) << (FRAC_W - WIDTH);
  assign w_n0 = (NW'(r_a) << w_lzc) << (FRAC_W - WIDTH);

  // One Goldschmidt step; products truncated back to FRAC_W fraction bits.
  assign w_dprod = {{DW{1'b0}}, r_d} * {{DW{1'b0}}, r_f};
  assign w_nprod = {{DW{1'b0}}, r_n} * {{NW{1'b0}}, r_f};
  assign w_d_new = w_dprod[FRAC_W +: DW];
  assign w_n_new = w_nprod[FRAC_W +: NW];

  assign w_est_sat  = f_sat(w_n_new[FRAC_W +: WIDTH + 1]);
  assign w_qtmp_sat = f_sat(r_n[FRAC_W +: WIDTH + 1]);

  // Correction: q_tmp is within one of the true quotient, so the residual
  // lies in (-b, 2b) and fits WIDTH+2 signed bits; modular low bits suffice.
  assign w_qb      = {{WIDTH{1'b0}}, r_qtmp} * {{WIDTH{1'b0}}, r_b};
  assign w_b_ext   = $signed({2'b00, r_b});
  assign w_rem     = $signed({2'b00, r_a}) - $signed(w_qb[RW-1:0]);
  assign w_rem_add = w_rem + w_b_ext;
  assign w_rem_sub = w_rem - w_b_ext;

  assign w_unused_bits = ^{w_dprod[2*DW-1:FRAC_W+DW], w_dprod[FRAC_W-1:0],
                           w_nprod[NW+DW-1:FRAC_W+NW], w_nprod[FRAC_W-1:0],
                           w_qb[2*WIDTH-1:RW], w_rem_add[RW-1:WIDTH],
                           w_rem_sub[RW-1:WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_est_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_est_q     <= '0;
      r_est_idx   <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_n         <= '0;
      r_d         <= '0;
      r_f         <= '0;
      r_qtmp      <= '0;
    end else if (i_en) begin
      r_est_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_in_ready <= 1'b0;
            if (i_b == '0) begin
              r_q     <= {WIDTH{1'b1}};
              r_r     <= i_a;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          r_d     <= w_d0;
          r_n     <= w_n0;
          r_f     <= c_TWO - w_d0;
          r_cnt   <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_n         <= w_n_new;
          r_d         <= w_d_new;
          r_f         <= c_TWO - w_d_new;
          r_est_valid <= 1'b1;
          r_est_idx   <= r_cnt;
          r_est_q     <= w_est_sat;
          if (r_cnt == c_LAST) begin
            r_state <= S_DENORM;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        S_DENORM: begin
          r_qtmp  <= w_qtmp_sat;
          r_state <= S_CORRECT;
        end
        S_CORRECT: begin
          if (w_rem[RW-1]) begin
            r_q <= r_qtmp - WIDTH'(1);
            r_r <= w_rem_add[WIDTH-1:0];
          end else if (w_rem >= w_b_ext) begin
            r_q <= r_qtmp + WIDTH'(1);
            r_r <= w_rem_sub[WIDTH-1:0];
          end else begin
            r_q <= r_qtmp;
            r_r <= w_rem[WIDTH-1:0];
          end
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Divide-by-zero arrives here with out_valid still low; raise it
          // one cycle later. Normal results arrive with it already set.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_q         = r_q;
  assign o_r         = r_r;
  assign o_dbz       = r_dbz;
  assign o_est_valid = r_est_valid;
  assign o_est_idx   = r_est_idx;
  assign o_est_q     = r_est_q;

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_goldschmidt_div
// Description : Directed and swept bench for goldschmidt_div at default
//               parameters, with a queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_div;

  localparam int W  = 32;
  localparam int IT = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic          dbz;
  logic          est_valid;
  logic [IW-1:0] est_idx;
  logic [W-1:0]  est_q;

  int total = 0;
  int bad   = 0;
  logic [2*W:0] sb_q[$];

  always #5 clk = ~clk;

  goldschmidt_div #(.WIDTH(W), .ITERS(IT), .FRAC_W(W + 2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (en),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_q         (q),
    .o_r         (r),
    .o_dbz       (dbz),
    .o_est_valid (est_valid),
    .o_est_idx   (est_idx),
    .o_est_q     (est_q)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input int hold, input int stall_at, input int stall_len,
                         output logic [W-1:0] last_est);
    logic [W-1:0] eq, er;
    logic         ed;
    logic [2*W:0] exp_ent;
    logic [36:0]  snap;
    int           lat, npulse, exp_lat;
    bit           seen, mono;
    longint       diff;

    if (tbv == '0) begin
      eq = '1; er = ta; ed = 1'b1;
    end else begin
      eq = ta / tbv; er = ta % tbv; ed = 1'b0;
    end
    sb_q.push_back({eq, er, ed});

    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;

    seen = 0; lat = 0; npulse = 0; mono = 1; last_est = '0;
    snap = {out_valid, est_valid, est_idx, est_q};
    for (int c = 1; c <= 200 && !seen; c++) begin
      en = !(c >= stall_at && c < stall_at + stall_len);
      @(posedge clk); #1;
      if (!en) begin
        chk("stall_freeze", {out_valid, est_valid, est_idx, est_q}, snap);
      end else if (est_valid) begin
        chk("est_idx", est_idx, npulse);
        if (est_q < last_est) mono = 0;
        last_est = est_q;
        npulse++;
      end
      snap = {out_valid, est_valid, est_idx, est_q};
      chk("busy_in_ready", in_ready, 0);
      if (out_valid) begin
        seen = 1;
        lat  = c;
      end
    end
    en = 1'b1;
    if (!seen) chk("out_valid_timeout", out_valid, 1);

    exp_lat = ((tbv == '0) ? 1 : IT + 3) + stall_len;
    chk("latency", lat, exp_lat);
    chk("est_count", npulse, (tbv == '0) ? 0 : IT);
    if (npulse > 0) begin
      chk("est_monotonic", mono, 1);
      diff = longint'(last_est) - longint'(eq);
      chk("est_last_near", (diff >= -1 && diff <= 1), 1);
    end

    exp_ent = sb_q.pop_front();
    chk("result", {q, r, dbz}, exp_ent);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", {q, r, dbz}, exp_ent);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake_out_valid", out_valid, 0);
    chk("handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] le;
    logic [W-1:0] ta, tbv;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_est_valid", est_valid, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_q_r", {q, r}, 0);
    chk("rst_est", {est_idx, est_q}, 0);

    run_div(32'd100, 32'd7, 0, 0, 0, le);
    chk("est_100_7_final", (le == 32'd13 || le == 32'd14), 1);

    run_div(32'hFFFF_FFFF, 32'd1, 0, 0, 0, le);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, le);
    run_div(32'd5, 32'd0, 0, 0, 0, le);
    run_div(32'd1000, 32'd33, 10, 0, 0, le);
    run_div(32'd123456789, 32'd1000, 0, 3, 3, le);

    // Reset in the middle of an iteration, with the stall also asserted.
    a = 32'd50; b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_est_valid", est_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle_out_valid", out_valid, 0);
    run_div(32'd9, 32'd3, 0, 0, 0, le);

    run_div(32'd0, 32'd1, 0, 0, 0, le);
    run_div(32'd0, 32'd77, 0, 0, 0, le);
    run_div(32'd3, 32'd10, 0, 0, 0, le);
    run_div(32'hDEAD_BEEF, 32'd1, 0, 0, 0, le);
    run_div(32'h8000_0000, 32'h8000_0001, 0, 0, 0, le);
    run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 0, le);
    run_div(32'hFFFF_FFFF, 32'd3, 0, 0, 0, le);

    for (int i = 1; i <= 30; i++) begin
      for (int j = 1; j <= 30; j++) begin
        ta  = (32'd1 << i) | ($urandom & ((32'd1 << i) - 32'd1));
        tbv = (32'd1 << j) | ($urandom & ((32'd1 << j) - 32'd1));
        run_div(ta, tbv, 0, 0, 0, le);
      end
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
